// File: rtl/reduction_frame_checker_pkg.sv
// Shared definitions for the reduction frame checker: flag bit positions,
// FSM state encoding and the per-beat consistency test on a flag vector.
package reduction_frame_checker_pkg;

    localparam int FLG_AND  = 5;
    localparam int FLG_NAND = 4;
    localparam int FLG_OR   = 3;
    localparam int FLG_NOR  = 2;
    localparam int FLG_XOR  = 1;
    localparam int FLG_XNOR = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Each flag pair is a value and its complement; equal bits mean a corrupt vector.
    function automatic logic is_malformed(input logic [5:0] f);
        return (f[FLG_AND] == f[FLG_NAND]) |
               (f[FLG_OR]  == f[FLG_NOR])  |
               (f[FLG_XOR] == f[FLG_XNOR]);
    endfunction

endpackage

// File: rtl/reduction_frame_checker_sat_counter.sv
// Saturating up-counter with a clear that can coincide with an increment,
// so the first beat of a frame is counted from zero in the same cycle.
module sat_counter #(
    parameter int CNT_W = 5,
    parameter int MAX   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             at_max
);

    assign at_max = (count == CNT_W'(MAX));

    always_comb begin
        // NOTE: give every always_comb output a default first so no path infers a latch.
        count_nxt = count;
        if (clr)
            count_nxt = CNT_W'(inc);
        else if (inc && !at_max)
            count_nxt = count + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments to avoid simulation races.
        if (rst)
            count <= '0;
        else
            count <= count_nxt;
    end

endmodule

// File: rtl/reduction_frame_checker.sv
// Accumulates per-frame parity, zero/ones nibble counts and length from a stream
// of reduction flag vectors and reports one summary per frame over valid/ready.
module reduction_frame_checker
    import reduction_frame_checker_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [5:0]       in_flags,
    input  logic             exp_parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic             out_malformed,
    output logic [CNT_W-1:0] out_zero_cnt,
    output logic [CNT_W-1:0] out_ones_cnt,
    output logic [CNT_W-1:0] out_len,
    output logic             out_overflow
);

    state_t state;
    logic   par, mal, ovf;
    logic   par_nxt, mal_nxt, ovf_nxt;
    logic   accept, clr, len_sat;

    logic [CNT_W-1:0] len_cnt, len_nxt, zero_cnt, zero_nxt, ones_cnt, ones_nxt;
    logic             len_at_max, zero_at_max, ones_at_max;

    assign in_ready = (state != REPORT);
    assign accept   = in_valid && in_ready;
    assign clr      = (state == IDLE);
    // Once the frame is full, the nibble counters freeze together with the length.
    assign len_sat  = len_at_max && !clr;

    sat_counter #(.CNT_W(CNT_W), .MAX(MAX_LEN)) u_len (
        .clk(clk), .rst(rst), .inc(accept), .clr(clr),
        .count(len_cnt), .count_nxt(len_nxt), .at_max(len_at_max)
    );

    sat_counter #(.CNT_W(CNT_W), .MAX(MAX_LEN)) u_zero (
        .clk(clk), .rst(rst), .inc(accept && in_flags[FLG_NOR] && !len_sat), .clr(clr),
        .count(zero_cnt), .count_nxt(zero_nxt), .at_max(zero_at_max)
    );

    sat_counter #(.CNT_W(CNT_W), .MAX(MAX_LEN)) u_ones (
        .clk(clk), .rst(rst), .inc(accept && in_flags[FLG_AND] && !len_sat), .clr(clr),
        .count(ones_cnt), .count_nxt(ones_nxt), .at_max(ones_at_max)
    );

    always_comb begin
        par_nxt = clr ? 1'b0 : par;
        mal_nxt = clr ? 1'b0 : mal;
        ovf_nxt = clr ? 1'b0 : ovf;
        if (accept) begin
            par_nxt = par_nxt ^ in_flags[FLG_XOR];
            mal_nxt = mal_nxt | is_malformed(in_flags);
            ovf_nxt = ovf_nxt | len_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            par           <= 1'b0;
            mal           <= 1'b0;
            ovf           <= 1'b0;
            out_valid     <= 1'b0;
            out_parity    <= 1'b0;
            out_err       <= 1'b0;
            out_malformed <= 1'b0;
            out_zero_cnt  <= '0;
            out_ones_cnt  <= '0;
            out_len       <= '0;
            out_overflow  <= 1'b0;
        end else begin
            par <= par_nxt;
            mal <= mal_nxt;
            ovf <= ovf_nxt;
            case (state)
                IDLE, ACCUM: begin
                    if (accept && in_last) begin
                        state         <= REPORT;
                        out_valid     <= 1'b1;
                        out_parity    <= par_nxt;
                        out_err       <= par_nxt ^ exp_parity;
                        out_malformed <= mal_nxt;
                        out_zero_cnt  <= zero_nxt;
                        out_ones_cnt  <= ones_nxt;
                        out_len       <= len_nxt;
                        out_overflow  <= ovf_nxt;
                    end else if (accept) begin
                        state <= ACCUM;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_at_max;
    assign unused_at_max = zero_at_max ^ ones_at_max;

endmodule

// File: tb/tb_reduction_frame_checker.sv
// Directed bench for reduction_frame_checker: stimulus pushes hand-computed
// summaries into a queue, a monitor pops and compares on each output handshake.
module tb_reduction_frame_checker;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_last, exp_parity;
    logic [5:0]       in_flags;
    logic             out_valid, out_ready;
    logic             out_parity, out_err, out_malformed, out_overflow;
    logic [CNT_W-1:0] out_zero_cnt, out_ones_cnt, out_len;

    typedef struct packed {
        logic       parity;
        logic       err;
        logic       mal;
        logic [4:0] zero;
        logic [4:0] ones;
        logic [4:0] len;
        logic       ovf;
    } summary_t;

    summary_t exp_q[$];
    summary_t snap;
    int checks   = 0;
    int failures = 0;

    reduction_frame_checker #(.MAX_LEN(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_flags(in_flags), .exp_parity(exp_parity),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity), .out_err(out_err), .out_malformed(out_malformed),
        .out_zero_cnt(out_zero_cnt), .out_ones_cnt(out_ones_cnt),
        .out_len(out_len), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic summary_t mk(input logic p, input logic e, input logic m,
                                    input int z, input int o, input int l, input logic v);
        summary_t s;
        s.parity = p; s.err = e; s.mal = m;
        s.zero = 5'(z); s.ones = 5'(o); s.len = 5'(l); s.ovf = v;
        return s;
    endfunction

    function automatic summary_t cur();
        summary_t s;
        s.parity = out_parity; s.err = out_err; s.mal = out_malformed;
        s.zero = out_zero_cnt; s.ones = out_ones_cnt; s.len = out_len; s.ovf = out_overflow;
        return s;
    endfunction

    // Monitor: every handshake about to happen at the next rising edge is checked.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_summary", cur(), 32'hffff_ffff);
            else
                check("summary", cur(), exp_q.pop_front());
        end
    end

    // Drives one beat, waits for acceptance; returns #1 after a rising edge.
    task automatic send_beat(input logic [5:0] f, input logic last, input logic ep);
        int  n;
        logic ok;
        n = 0;
        in_valid = 1'b1; in_flags = f; in_last = last; exp_parity = ep;
        do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1; n++;
        end while (!ok && n < 50);
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0; in_last = 1'b0;
        if (last) begin
            @(negedge clk);
            check("latency_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b1; in_flags = 6'h3f; in_last = 1'b1;
        exp_parity = 1'b1; out_ready = 1'b1;

        // Reset with junk beats offered
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_outputs", cur(), 0);
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;

        // Clean frame
        exp_q.push_back(mk(1, 0, 0, 1, 1, 4, 0));
        send_beat(6'b010101, 0, 1);
        send_beat(6'b011001, 0, 1);
        send_beat(6'b011010, 0, 1);
        send_beat(6'b101001, 1, 1);

        // Same frame, parity mismatch
        exp_q.push_back(mk(1, 1, 0, 1, 1, 4, 0));
        send_beat(6'b010101, 0, 0);
        send_beat(6'b011001, 0, 0);
        send_beat(6'b011010, 0, 0);
        send_beat(6'b101001, 1, 0);

        // Single-beat frame held under backpressure
        out_ready = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0));
        send_beat(6'b101001, 1, 0);
        in_valid = 1'b1; in_flags = 6'h3f; in_last = 1'b1; exp_parity = 1'b1;
        @(negedge clk);
        snap = cur();
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_in_ready_hold", in_ready, 0);
            check("bp_out_valid_hold", out_valid, 1);
            check("bp_outputs_stable", cur(), snap);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Next frame starts from zero
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        send_beat(6'b011010, 1, 1);

        // Overflow: 18 zero nibbles
        exp_q.push_back(mk(0, 0, 0, 16, 0, 16, 1));
        for (int i = 0; i < 18; i++)
            send_beat(6'b010101, (i == 17), 0);

        // Malformed beat
        exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 0));
        send_beat(6'b110101, 1, 0);

        // Mid-frame reset discards the partial frame
        for (int i = 0; i < 3; i++)
            send_beat(6'b010101, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 2, 0));
        send_beat(6'b011001, 0, 0);
        send_beat(6'b011001, 1, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
